// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 load/store unit: funct3 encodings,
// LSU FSM states and lane-geometry helpers.
package ysyx_24100005_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Number of byte lanes in a data word.
    function automatic int lsu_nbytes(input int xlen);
        return xlen / 8;
    endfunction

    // Width of the byte offset inside a data word.
    function automatic int lsu_offw(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational lane logic: byte mask and shifted store data, extracted and
// extended load data, and legality/alignment flags for one access.
module ysyx_24100005_lsu_align
    import ysyx_24100005_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                        we,
    input  logic [2:0]                  funct3,
    input  logic [lsu_offw(XLEN)-1:0]   offset,
    input  logic [XLEN-1:0]             wdata,
    input  logic [XLEN-1:0]             rdata,
    output logic [lsu_nbytes(XLEN)-1:0] wmask,
    output logic [XLEN-1:0]             wdata_sh,
    output logic [XLEN-1:0]             rdata_ext,
    output logic                        illegal,
    output logic                        misaligned
);
    localparam int NB = lsu_nbytes(XLEN);

    logic [7:0]      ones8;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_s;
    logic [XLEN-1:0] word_u;

    always_comb begin
        ones8 = 8'h01;
        case (funct3[1:0])
            2'b00:   ones8 = 8'h01;
            2'b01:   ones8 = 8'h03;
            2'b10:   ones8 = 8'h0f;
            default: ones8 = 8'hff;
        endcase
    end

    // Shifting within the word truncates anything that would spill past it.
    assign wmask    = we ? (ones8[NB-1:0] << offset) : '0;
    assign wdata_sh = wdata << {offset, 3'b000};
    assign shifted  = rdata >> {offset, 3'b000};

    generate
        if (XLEN == 64) begin : g_word64
            assign word_s = {{32{shifted[31]}}, shifted[31:0]};
            assign word_u = {32'b0, shifted[31:0]};
        end else begin : g_word32
            assign word_s = shifted;
            assign word_u = shifted;
        end
    endgenerate

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_LB:   rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LW:   rdata_ext = word_s;
            F3_LWU:  rdata_ext = word_u;
            F3_LD:   rdata_ext = shifted;
            default: rdata_ext = '0;
        endcase
    end

    always_comb begin
        illegal = 1'b1;
        if (we) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: illegal = 1'b0;
                F3_SD:               illegal = (XLEN != 64);
                default:             illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
                F3_LD, F3_LWU:                       illegal = (XLEN != 64);
                default:                             illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> WAIT -> RESP handshake with data memory.
// Define YSYX_24100005_LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module ysyx_24100005_lsu
    import ysyx_24100005_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [2:0]                  req_funct3,
    input  logic [AW-1:0]               req_addr,
    input  logic [XLEN-1:0]             req_wdata,
    output logic                        resp_valid,
    output logic [XLEN-1:0]             resp_rdata,
    output logic                        resp_err,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic                        mem_wen,
    output logic [AW-1:0]               mem_addr,
    output logic [lsu_nbytes(XLEN)-1:0] mem_wmask,
    output logic [XLEN-1:0]             mem_wdata,
    input  logic                        mem_rvalid,
    input  logic [XLEN-1:0]             mem_rdata
);
    localparam int NB = lsu_nbytes(XLEN);
    localparam int OW = lsu_offw(XLEN);
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    lsu_state_e      state_reg, state_next;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [AW-1:0]   addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] rdata_reg;
    logic            err_reg;

    logic            accept;
    logic            req_bad;
    logic            sel_we;
    logic [2:0]      sel_funct3;
    logic [OW-1:0]   sel_offset;
    logic [NB-1:0]   al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_illegal;
    logic            al_misaligned;

    assign accept = (state_reg == ST_IDLE) && req_valid;

    // One aligner serves both the incoming request (legality in IDLE) and the held one.
    assign sel_we     = (state_reg == ST_IDLE) ? req_we : we_reg;
    assign sel_funct3 = (state_reg == ST_IDLE) ? req_funct3 : funct3_reg;
    assign sel_offset = (state_reg == ST_IDLE) ? req_addr[OW-1:0] : addr_reg[OW-1:0];
    assign req_bad    = al_illegal | (TRAP_EN & al_misaligned);

    ysyx_24100005_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .we         (sel_we),
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .wdata      (wdata_reg),
        .rdata      (mem_rdata),
        .wmask      (al_wmask),
        .wdata_sh   (al_wdata),
        .rdata_ext  (al_rdata),
        .illegal    (al_illegal),
        .misaligned (al_misaligned)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_valid) state_next = req_bad ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= req_we;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                rdata_reg  <= '0;
                err_reg    <= req_bad;
            end else if ((state_reg == ST_WAIT) && mem_rvalid) begin
                rdata_reg <= we_reg ? '0 : al_rdata;
            end
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign mem_valid  = (state_reg == ST_REQ);
    assign mem_wen    = mem_valid & we_reg;
    assign mem_addr   = mem_valid ? {addr_reg[AW-1:OW], {OW{1'b0}}} : '0;
    assign mem_wmask  = mem_valid ? al_wmask : '0;
    assign mem_wdata  = mem_valid ? al_wdata : '0;
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_reg : '0;
    assign resp_err   = resp_valid & err_reg;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Scoreboard bench for ysyx_24100005_lsu (XLEN=32); expectations follow
// YSYX_24100005_LSU_MISALIGN_TRAP_EN when it is defined.
module tb_ysyx_24100005_lsu;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } resp_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cfg_rdy = 0;
    int cfg_rv  = 0;
    logic [31:0] cfg_mrd = 32'b0;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    assign mem_rdata = cfg_mrd;

    ysyx_24100005_lsu #(.XLEN(32), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: ready after cfg_rdy stall cycles, rvalid after cfg_rv idle cycles.
    initial begin
        int  rdy_left;
        int  rv_left;
        bit  pending;
        rdy_left = -1;
        rv_left  = 0;
        pending  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst) begin
                rdy_left = -1;
                pending  = 1'b0;
            end else if (pending) begin
                if (rv_left == 0) begin
                    mem_rvalid = 1'b1;
                    pending    = 1'b0;
                end else begin
                    rv_left--;
                end
            end else if (mem_valid) begin
                if (rdy_left < 0) rdy_left = cfg_rdy;
                if (rdy_left == 0) begin
                    mem_ready = 1'b1;
                    rdy_left  = -1;
                    pending   = 1'b1;
                    rv_left   = cfg_rv;
                end else begin
                    rdy_left--;
                end
            end
        end
    end

    // Monitor: compares memory requests and responses against the scoreboard queues.
    initial begin
        bit          prev_stall;
        bit          prev_resp;
        logic [31:0] prev_addr;
        mem_exp_t    me;
        resp_exp_t   re;
        prev_stall = 1'b0;
        prev_resp  = 1'b0;
        prev_addr  = 32'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_stall) begin
                    check("mem_valid_held", {63'b0, mem_valid}, 64'd1);
                    check("mem_addr_held", {32'b0, mem_addr}, {32'b0, prev_addr});
                end
                if (prev_resp) check("resp_one_cycle", {63'b0, resp_valid}, 64'd0);
                if (mem_valid) check("req_ready_busy", {63'b0, req_ready}, 64'd0);
                if (mem_valid && mem_ready) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", {63'b0, mem_valid}, 64'd0);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_addr", {32'b0, mem_addr}, {32'b0, me.addr});
                        check("mem_wen", {63'b0, mem_wen}, {63'b0, me.wen});
                        check("mem_wmask", {60'b0, mem_wmask}, {60'b0, me.wmask});
                        check("mem_wdata", {32'b0, mem_wdata}, {32'b0, me.wdata});
                    end
                end
                if (resp_valid) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_resp", {63'b0, resp_valid}, 64'd0);
                    end else begin
                        re = resp_q.pop_front();
                        $display("[TB] resp t=%0d rdata=0x%08h err=%0d lat=%0d",
                                 cyc, resp_rdata, resp_err, cyc - re.acc);
                        check("resp_rdata", {32'b0, resp_rdata}, {32'b0, re.rdata});
                        check("resp_err", {63'b0, resp_err}, {63'b0, re.err});
                        if (re.lat > 0)
                            check("resp_latency", 64'(cyc - re.acc), 64'(re.lat));
                    end
                end
            end
            prev_stall = rst && mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_resp  = rst && resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mrd,
                         input int rdy, input int rv,
                         input logic exp_mem, input logic [31:0] e_addr,
                         input logic [3:0] e_mask, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                         input bit wait_resp);
        bit accepted;
        bit done;
        cfg_rdy = rdy;
        cfg_rv  = rv;
        cfg_mrd = mrd;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        accepted   = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
        end
        check("req_accepted", {63'b0, accepted}, 64'd1);
        if (accepted) begin
            if (exp_mem) mem_q.push_back('{addr: e_addr, wen: we, wmask: e_mask, wdata: e_wdata});
            resp_q.push_back('{rdata: e_rdata, err: e_err, acc: cyc, lat: e_lat});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wait_resp) begin
            done = 1'b0;
            for (int i = 0; i < 60 && !done; i++) begin
                @(negedge clk);
                if (resp_q.size() == 0) done = 1'b1;
            end
            check("resp_timeout", {63'b0, done}, 64'd1);
            if (!done) begin
                mem_q.delete();
                resp_q.delete();
            end
        end
    endtask

    localparam logic [31:0] RD = 32'h1280_3456;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_mem_valid", {63'b0, mem_valid}, 64'd0);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_outputs", {32'b0, mem_addr | mem_wdata | resp_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // SW / SB / SH store lane placement
        issue(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0,
              1'b1, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b1);
        issue(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0,
              1'b1, 32'h8000_0000, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0, 3, 1'b1);
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 0,
              1'b1, 32'h8000_0000, 4'b1100, 32'hABCD_0000, 32'h0, 1'b0, 3, 1'b1);
        // Load extraction and extension
        issue(1'b0, 3'b000, 32'h8000_0002, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b100, 32'h8000_0002, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b001, 32'h8000_0002, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_1280, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b101, 32'h8000_0000, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_3456, 1'b0, 3, 1'b1);
        // Backpressure: 4 stall cycles in REQ, 3 idle cycles in WAIT
        issue(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 4, 3,
              1'b1, 32'h8000_0008, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 10, 1'b1);
        // Illegal funct3, both builds
        issue(1'b0, 3'b111, 32'h8000_0000, 32'h0, RD, 0, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b1, 3'b100, 32'h8000_0000, 32'h5555_5555, RD, 0, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h8000_0001, 32'h0, RD, 0, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b0, 3'b001, 32'h8000_0001, 32'h0, RD, 0, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b1, 3'b010, 32'h8000_0002, 32'h1122_3344, RD, 0, 0,
              1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
`else
        issue(1'b0, 3'b010, 32'h8000_0001, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'h0012_8034, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b001, 32'h8000_0001, 32'h0, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_8034, 1'b0, 3, 1'b1);
        issue(1'b1, 3'b010, 32'h8000_0002, 32'h1122_3344, RD, 0, 0,
              1'b1, 32'h8000_0000, 4'b1100, 32'h3344_0000, 32'h0, 1'b0, 3, 1'b1);
`endif

        // Reset while in WAIT abandons the transaction
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, RD, 0, 20,
              1'b1, 32'h8000_0010, 4'b0000, 32'h0, RD, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_valid", {63'b0, mem_valid}, 64'd0);
        check("arst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("arst_req_ready", {63'b0, req_ready}, 64'd1);
        check("arst_mem_drained", 64'(mem_q.size()), 64'd0);
        resp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 3'b010, 32'h8000_0020, 32'h0BAD_F00D, 32'h0, 0, 0,
              1'b1, 32'h8000_0020, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b0, 3, 1'b1);

        repeat (3) @(posedge clk);
        check("mem_q_empty", 64'(mem_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
